// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction fetch sequencer; define FETCH_PERF_EN to add the fetch_count port
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FETCH_PERF_EN
    output logic [15:0] fetch_count,
`endif
    input  logic        stall,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_take,
    input  logic        br_decr,
    input  logic [15:0] br_diff,
    input  logic        jmp_take,
    input  logic [15:0] jmp_target,
    output logic [15:0] pc_curr,
    output logic        pc_decr,
    output logic [15:0] pc_diff,
    input  logic [15:0] pc_next
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t      state;
    logic [15:0] pc;
    logic        br_sel;
    assign br_sel   = br_take && !jmp_take;
    assign mem_addr = pc;
    assign pc_curr  = pc;
    assign pc_decr  = br_sel ? br_decr : 1'b0;
    assign pc_diff  = br_sel ? br_diff : 16'h0001;
    assign mem_rd   = (state == REQ) && !stall;
    // fetch sequencing: redirects override everything but reset and drop any ack in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= IDLE;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (jmp_take || br_take) begin
            pc          <= jmp_take ? jmp_target : pc_next;
            instr_valid <= 1'b0;
            state       <= REQ;
        end else begin
            case (state)
                IDLE: if (!stall) state <= REQ;
                REQ: if (mem_ack && !stall) begin
                    instr       <= mem_rdata;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    pc          <= pc_next;
                    state       <= HOLD;
                end
                HOLD: if (instr_ready && !stall) begin
                    instr_valid <= 1'b0;
                    state       <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef FETCH_PERF_EN
    // saturating count of handshake cycles; survives redirects
    always_ff @(posedge clk) begin
        if (reset) fetch_count <= '0;
        else if (instr_valid && instr_ready && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'h0001;
    end
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: randomized scoreboard bench for pc_fetch_ctrl with an instruction-stream reference model
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset, stall, mem_ack, instr_ready, br_take, br_decr, jmp_take;
    logic [15:0] mem_rdata, br_diff, jmp_target, pc_next;
    logic [15:0] mem_addr, instr, instr_pc, pc_curr, pc_diff;
    logic        mem_rd, instr_valid, pc_decr;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] mcnt;
`endif

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset),
`ifdef FETCH_PERF_EN
        .fetch_count(fetch_count),
`endif
        .stall(stall), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .br_take(br_take), .br_decr(br_decr), .br_diff(br_diff), .jmp_take(jmp_take), .jmp_target(jmp_target),
        .pc_curr(pc_curr), .pc_decr(pc_decr), .pc_diff(pc_diff), .pc_next(pc_next)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    assign mem_rdata = mem_word(mem_addr);
    assign pc_next   = pc_decr ? pc_curr - pc_diff : pc_curr + pc_diff;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {logic [15:0] w; logic [15:0] a;} item_t;
    item_t       q[$];
    logic [15:0] mpc = 16'h0000;
    bit          idle = 1'b1;
    bit          armed = 1'b0;
    bit          just_reset = 1'b0;

    // reference model: architectural pc plus the queue of fetched-but-unaccepted words; checks then advances
    always @(negedge clk) begin
        bit   pres;
        bit   redir;
        logic [15:0] ediff;
        pres  = q.size() != 0;
        redir = jmp_take || br_take;
        ediff = (br_take && !jmp_take) ? br_diff : 16'h0001;
        if (armed) begin
            chk("mem_addr", mem_addr, mpc);
            chk("pc_curr", pc_curr, mpc);
            chk("mem_rd", 16'(mem_rd), 16'(!idle && !pres && !stall));
            chk("instr_valid", 16'(instr_valid), 16'(pres));
            chk("pc_decr", 16'(pc_decr), 16'(br_take && !jmp_take && br_decr));
            chk("pc_diff", pc_diff, ediff);
            if (just_reset) begin
                chk("rst_instr", instr, 16'h0000);
                chk("rst_instr_pc", instr_pc, 16'h0000);
            end
            if (pres) begin
                chk("instr", instr, q[0].w);
                chk("instr_pc", instr_pc, q[0].a);
            end
`ifdef FETCH_PERF_EN
            chk("fetch_count", fetch_count, mcnt);
`endif
        end
        if (reset) begin
            armed = 1'b1;
            mpc   = 16'h0000;
            idle  = 1'b1;
            q.delete();
`ifdef FETCH_PERF_EN
            mcnt  = 16'h0000;
`endif
        end else if (armed) begin
`ifdef FETCH_PERF_EN
            if (pres && instr_ready && mcnt != 16'hFFFF) mcnt++;
`endif
            if (redir) begin
                mpc  = jmp_take ? jmp_target : (br_decr ? mpc - br_diff : mpc + br_diff);
                idle = 1'b0;
                q.delete();
            end else if (idle) begin
                idle = stall;
            end else if (pres) begin
                if (instr_ready && !stall) void'(q.pop_front());
            end else if (mem_ack && !stall) begin
                q.push_back('{mem_word(mpc), mpc});
                mpc++;
            end
        end
        just_reset = reset;
    end

    // stimulus and memory responder with random ack latency
    initial begin
        int  lat;
        bit  clean;
        lat = 0;
        reset = 1'b1; stall = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        br_take = 1'b0; br_decr = 1'b0; br_diff = '0; jmp_take = 1'b0; jmp_target = '0;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 4000; c++) begin
            #1;
            clean       = c < 30;
            reset       = !clean && $urandom_range(0, 199) == 0;
            stall       = !clean && $urandom_range(0, 4) == 0;
            instr_ready = clean || $urandom_range(0, 9) < 7;
            jmp_take    = !clean && $urandom_range(0, 39) == 0;
            br_take     = !clean && $urandom_range(0, 29) == 0;
            br_decr     = 1'($urandom_range(0, 1));
            br_diff     = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 20));
            case ($urandom_range(0, 3))
                0: jmp_target = 16'hFFFF;
                1: jmp_target = 16'hFFFE;
                2: jmp_target = 16'h0000;
                default: jmp_target = 16'($urandom);
            endcase
            #1;
            mem_ack = mem_rd && lat == 0;
            if (mem_rd) lat = mem_ack ? (clean ? 0 : $urandom_range(0, 3)) : lat - 1;
            @(posedge clk);
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program counter register and instruction-fetch sequencer for the 16-bit datapath. Owns the architectural PC, drives the PC incrementer (curr_pc/decr/diff out, next_pc back in), issues instruction reads to memory, and presents each fetched word to the decoder with a valid/ready handshake. Branches and jumps from execute redirect the PC and flush the fetch.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  freezes request issue and instruction release
- mem_addr  out  16  instruction read address (always equals pc register)
- mem_rd  out  1  read request, held until mem_ack
- mem_ack  in  1  read complete this cycle; mem_rdata valid
- mem_rdata  in  16  instruction word
- instr  out  16  fetched instruction
- instr_pc  out  16  address instr was fetched from
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decoder accepts instr this cycle
- br_take  in  1  relative branch request
- br_decr  in  1  1 = branch backward (subtract)
- br_diff  in  16  unsigned branch magnitude
- jmp_take  in  1  absolute jump request
- jmp_target  in  16  jump address
- pc_curr  out  16  to incrementer curr_pc
- pc_decr  out  1  to incrementer decr
- pc_diff  out  16  to incrementer diff
- pc_next  in  16  from incrementer next_pc
- fetch_count  out  16  only with FETCH_PERF_EN (see Configuration)

## Operation
- States: IDLE, REQ, HOLD. Reset -> IDLE.
- IDLE: mem_rd=0. Next: REQ unless stall.
- REQ: mem_rd=1 when !stall, else 0. On mem_ack && !stall (no redirect): instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc_next, -> HOLD. mem_ack while stall is ignored (memory must not ack without mem_rd).
- HOLD: instr_valid=1, mem_rd=0. On instr_ready && !stall: instr_valid<=0, -> REQ. Otherwise hold all outputs stable.
- Incrementer drive (combinational): pc_curr=pc always. If br_take && !jmp_take: pc_decr=br_decr, pc_diff=br_diff; else pc_decr=0, pc_diff=16'h0001.
- Redirect (any state, ignores stall): priority reset > jmp_take > br_take. jmp: pc<=jmp_target. br: pc<=pc_next (i.e. pc ± br_diff, pc = current register value). Both: instr_valid<=0, state -> REQ, any mem_ack in the same cycle is discarded (no capture, no pc advance).
- Arithmetic is 16-bit modulo; 0xFFFF+1 = 0x0000, 0x0000-1 = 0xFFFF (incrementer behaviour, no flag).

## Timing
- Reset values: pc=RESET_PC, state=IDLE, instr=0, instr_pc=0, instr_valid=0, mem_rd=0, mem_addr=RESET_PC, fetch_count=0.
- First edge with reset low: IDLE->REQ; mem_rd high the following cycle.
- mem_ack in cycle N -> instr_valid high in N+1, mem_addr = old pc+1 in N+1.
- Accept (instr_ready) in cycle M -> mem_rd high in M+1. Zero-wait throughput: one instruction per 2 cycles.
- mem_addr and mem_rd stable while waiting for mem_ack.
- Redirect in cycle R -> mem_addr = new pc and mem_rd=1 in R+1 (if !stall).
- Reset mid-fetch: outstanding read abandoned, reset values next cycle.

## Configuration
- FETCH_PERF_EN defined: adds fetch_count port; 16-bit counter increments on each instr_valid && instr_ready cycle, saturates at 16'hFFFF, cleared by reset, not cleared by redirect.
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset, RESET_PC=0, memory acks same cycle returning 0xA000|addr -> instr 0xA000/instr_pc 0x0000, then 0xA001/0x0001, one per 2 cycles with instr_ready=1.
- mem_ack delayed 3 cycles at pc 0x0005 -> mem_rd=1, mem_addr=0x0005 stable 3 cycles; instr_valid rises cycle after ack.
- pc=0x0010 in HOLD, br_take=1, br_decr=1, br_diff=4 -> pc_decr=1, pc_diff=4 that cycle; instr_valid drops; next mem_addr 0x000C.
- jmp_take (0x0200) and br_take same cycle as mem_ack -> ack discarded, next mem_addr 0x0200; jmp_target 0xFFFF fetch -> next mem_addr 0x0000.
- stall high 4 cycles in HOLD with instr_ready=1 -> instr/instr_valid unchanged, mem_rd=0; release -> accepted, REQ next cycle.
- FETCH_PERF_EN: 3 accepted instructions -> fetch_count=3; reset mid-wait -> fetch_count=0, mem_rd=0, mem_addr=RESET_PC.
